// File: rtl/r_format_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for the R-format datapath.
// Optional single-step mode (step port, PAUSE state) enabled by SEQ_SINGLE_STEP_EN.
module r_format_sequencer #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] MAX_INSTR = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [31:0] instr_addr,
  input  logic [31:0] instruction,
  output logic [31:0] ir,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
`ifdef SEQ_SINGLE_STEP_EN
    , S_PAUSE   = 3'd6
`endif
  } state_t;

  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;

  state_t      state_q;
  state_t      state_d;
  state_t      state_cont;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic        illegal_q;
  logic [31:0] retired_q;
  logic        stop_pending_q;

  logic        load_ir;
  logic        set_illegal;
  logic        clr_illegal;
  logic        retire;
  logic        opcode_bad;
  logic        rd_nonzero;
  logic [31:0] retired_next;
  logic        max_hit;
  logic        enter_halt;

  assign opcode_bad   = |ir_q[31:26];
  assign rd_nonzero   = |ir_q[15:11];
  assign retired_next = (&retired_q) ? retired_q : retired_q + 32'd1;
  assign max_hit      = (MAX_INSTR != 32'd0) && (retired_next == MAX_INSTR);
  assign enter_halt   = (state_d == S_HALT) && (state_q != S_HALT);

`ifdef SEQ_SINGLE_STEP_EN
  assign state_cont = S_PAUSE;
`else
  assign state_cont = S_FETCH;
`endif

  // Next-state logic and per-state control strobes.
  always_comb begin
    state_d     = state_q;
    load_ir     = 1'b0;
    set_illegal = 1'b0;
    clr_illegal = 1'b0;
    retire      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        load_ir = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode_bad) begin
          set_illegal = 1'b1;
          state_d     = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        retire = 1'b1;
        if (stop_pending_q || stop || max_hit)
          state_d = S_HALT;
        else
          state_d = state_cont;
      end
      S_HALT: begin
        if (start) begin
          clr_illegal = 1'b1;
          state_d     = S_FETCH;
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      S_PAUSE: begin
        if (stop)
          state_d = S_HALT;
        else if (step)
          state_d = S_FETCH;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from state and latched instruction only.
  always_comb begin
    busy      = 1'b0;
    halted    = 1'b0;
    alu_op    = ALU_OP_ADD;
    reg_write = 1'b0;
    unique case (1'b1)
      (state_q == S_FETCH),
      (state_q == S_DECODE): begin
        busy = 1'b1;
      end
      (state_q == S_EXECUTE): begin
        busy   = 1'b1;
        alu_op = ALU_OP_R;
      end
      (state_q == S_WRITEBACK): begin
        busy      = 1'b1;
        alu_op    = ALU_OP_R;
        reg_write = rd_nonzero;
      end
      (state_q == S_HALT): begin
        halted = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Program counter advances only when an instruction retires.
  always_ff @(posedge clk) begin
    if (rst)         pc_q <= PC_RESET;
    else if (retire) pc_q <= pc_q + PC_STEP;
  end

  // Instruction register captures memory data at the end of FETCH.
  always_ff @(posedge clk) begin
    if (rst)          ir_q <= 32'd0;
    else if (load_ir) ir_q <= instruction;
  end

  // Sticky illegal-opcode flag, cleared by restarting from HALT.
  always_ff @(posedge clk) begin
    if (rst)              illegal_q <= 1'b0;
    else if (set_illegal) illegal_q <= 1'b1;
    else if (clr_illegal) illegal_q <= 1'b0;
  end

  // Saturating retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst)         retired_q <= 32'd0;
    else if (retire) retired_q <= retired_next;
  end

  // Remembers a stop seen mid-instruction until HALT is reached.
  always_ff @(posedge clk) begin
    if (rst)               stop_pending_q <= 1'b0;
    else if (enter_halt)   stop_pending_q <= 1'b0;
    else if (stop && busy) stop_pending_q <= 1'b1;
  end

  assign instr_addr = pc_q;
  assign ir         = ir_q;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_r_format_sequencer.sv
// Directed bench for r_format_sequencer with a small RF/ALU model.
// Single-step scenario runs when SEQ_SINGLE_STEP_EN is defined.
module tb_r_format_sequencer;

  localparam logic [31:0] ADD  = 32'h0022_1820;
  localparam logic [31:0] SUB  = 32'h0041_2022;
  localparam logic [31:0] ORR  = 32'h0022_2825;
  localparam logic [31:0] ADD0 = 32'h0022_0020;
  localparam logic [31:0] LW   = 32'h8C01_0000;

  logic        clk = 1'b0;
  logic        rst, start, stop, start2;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step, step2;
`endif
  logic [31:0] instr_addr, instruction, ir, retired;
  logic [1:0]  alu_op;
  logic        reg_write, busy, halted, illegal;
  logic [31:0] instr_addr2, instruction2, ir2, retired2;
  logic [1:0]  alu_op2;
  logic        reg_write2, busy2, halted2, illegal2;

  logic [31:0] mem [0:15];
  logic [31:0] rf  [0:31];
  logic [31:0] alu_res;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign instruction  = mem[instr_addr[5:2]];
  assign instruction2 = ADD;

  r_format_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .instr_addr(instr_addr), .instruction(instruction), .ir(ir),
    .alu_op(alu_op), .reg_write(reg_write), .busy(busy),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  r_format_sequencer #(
    .PC_RESET(32'hFFFF_FFF8), .PC_STEP(32'd4), .MAX_INSTR(32'd2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(1'b0),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step2),
`endif
    .instr_addr(instr_addr2), .instruction(instruction2), .ir(ir2),
    .alu_op(alu_op2), .reg_write(reg_write2), .busy(busy2),
    .halted(halted2), .illegal(illegal2), .retired(retired2)
  );

  // Reference ALU for the R-type functs used by the vectors.
  always_comb begin
    alu_res = 32'd0;
    case (ir[5:0])
      6'h20: alu_res = rf[ir[25:21]] + rf[ir[20:16]];
      6'h22: alu_res = rf[ir[25:21]] - rf[ir[20:16]];
      6'h24: alu_res = rf[ir[25:21]] & rf[ir[20:16]];
      6'h25: alu_res = rf[ir[25:21]] | rf[ir[20:16]];
      default: alu_res = 32'd0;
    endcase
  end

  // Register file model; any reg_write lands, so a stray $0 write shows up.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd5;
      rf[2] <= 32'd7;
    end else if (reg_write) begin
      rf[ir[15:11]] <= alu_res;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic fill_mem(input logic [31:0] w);
    for (int i = 0; i < 16; i++) mem[i] = w;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; start2 = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
    step = 1'b0; step2 = 1'b0;
`endif
    repeat (2) tick;
    rst = 1'b0;
  endtask

  task automatic run_start;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    fill_mem(ADD);
    do_reset;
    checks++;
    if (instr_addr !== 32'h0) begin
      fails++; $display("FAIL reset_addr: got %h want 00000000", instr_addr);
    end
    checks++;
    if (ir !== 32'h0 || retired !== 32'h0 || illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs: ir=%h retired=%0d illegal=%b want 0/0/0", ir, retired, illegal);
    end
    checks++;
    if ({alu_op, reg_write, busy, halted} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 00000", {alu_op, reg_write, busy, halted});
    end
    checks++;
    if (instr_addr2 !== 32'hFFFF_FFF8) begin
      fails++; $display("FAIL reset_addr2: got %h want fffffff8", instr_addr2);
    end
  endtask

  task automatic test_single_add;
    fill_mem(ADD);
    do_reset;
    run_start;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (reg_write !== (k == 4)) begin
        fails++; $display("FAIL add_rw c%0d: got %b want %b", k, reg_write, k == 4);
      end
      checks++;
      if (alu_op !== ((k >= 3) ? 2'b10 : 2'b00)) begin
        fails++; $display("FAIL add_aluop c%0d: got %b", k, alu_op);
      end
      checks++;
      if (busy !== 1'b1) begin
        fails++; $display("FAIL add_busy c%0d: got %b want 1", k, busy);
      end
      if (k == 2) begin
        checks++;
        if (ir !== ADD) begin
          fails++; $display("FAIL add_ir: got %h want %h", ir, ADD);
        end
      end
      tick;
    end
    checks++;
    if (instr_addr !== 32'd4 || retired !== 32'd1) begin
      fails++; $display("FAIL add_retire: addr=%h retired=%0d want 4/1", instr_addr, retired);
    end
    checks++;
    if (rf[3] !== 32'd12) begin
      fails++; $display("FAIL add_result: got %0d want 12", rf[3]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ea;
    fill_mem(ADD);
    mem[1] = SUB;
    mem[2] = ORR;
    do_reset;
    run_start;
    for (int k = 1; k <= 12; k++) begin
      ea = 32'(((k - 1) / 4) * 4);
      checks++;
      if (reg_write !== (k % 4 == 0)) begin
        fails++; $display("FAIL b2b_rw c%0d: got %b", k, reg_write);
      end
      checks++;
      if (alu_op !== ((k % 4 == 3 || k % 4 == 0) ? 2'b10 : 2'b00)) begin
        fails++; $display("FAIL b2b_aluop c%0d: got %b", k, alu_op);
      end
      checks++;
      if (instr_addr !== ea) begin
        fails++; $display("FAIL b2b_addr c%0d: got %h want %h", k, instr_addr, ea);
      end
      tick;
    end
    checks++;
    if (instr_addr !== 32'd12 || retired !== 32'd3) begin
      fails++; $display("FAIL b2b_end: addr=%h retired=%0d want c/3", instr_addr, retired);
    end
    checks++;
    if (rf[3] !== 32'd12 || rf[4] !== 32'd2 || rf[5] !== 32'd7) begin
      fails++; $display("FAIL b2b_rf: r3=%0d r4=%0d r5=%0d want 12/2/7", rf[3], rf[4], rf[5]);
    end
  endtask

  task automatic test_rd_zero;
    int pulses;
    fill_mem(ADD);
    mem[0] = ADD0;
    pulses = 0;
    do_reset;
    run_start;
    repeat (4) begin
      if (reg_write) pulses++;
      tick;
    end
    checks++;
    if (pulses != 0) begin
      fails++; $display("FAIL rd0_rw: got %0d pulses want 0", pulses);
    end
    checks++;
    if (retired !== 32'd1 || instr_addr !== 32'd4) begin
      fails++; $display("FAIL rd0_retire: retired=%0d addr=%h want 1/4", retired, instr_addr);
    end
    checks++;
    if (rf[0] !== 32'd0) begin
      fails++; $display("FAIL rd0_r0: got %0d want 0", rf[0]);
    end
  endtask

  task automatic test_illegal;
    fill_mem(ADD);
    mem[2] = LW;
    do_reset;
    run_start;
    repeat (10) tick;
    checks++;
    if ({halted, illegal, busy} !== 3'b110) begin
      fails++; $display("FAIL ill_halt: h/i/b=%b want 110", {halted, illegal, busy});
    end
    checks++;
    if (instr_addr !== 32'd8 || retired !== 32'd2) begin
      fails++; $display("FAIL ill_pc: addr=%h retired=%0d want 8/2", instr_addr, retired);
    end
    checks++;
    if (ir !== LW || alu_op !== 2'b00 || reg_write !== 1'b0) begin
      fails++; $display("FAIL ill_ctrl: ir=%h op=%b rw=%b", ir, alu_op, reg_write);
    end
    repeat (2) tick;
    checks++;
    if (halted !== 1'b1 || instr_addr !== 32'd8) begin
      fails++; $display("FAIL ill_hold: halted=%b addr=%h want 1/8", halted, instr_addr);
    end
    run_start;
    checks++;
    if ({illegal, busy, halted} !== 3'b010) begin
      fails++; $display("FAIL ill_restart: i/b/h=%b want 010", {illegal, busy, halted});
    end
    repeat (2) tick;
    checks++;
    if ({halted, illegal} !== 2'b11 || instr_addr !== 32'd8 || retired !== 32'd2) begin
      fails++;
      $display("FAIL ill_again: h/i=%b addr=%h retired=%0d", {halted, illegal}, instr_addr, retired);
    end
  endtask

  task automatic test_stop;
    fill_mem(ADD);
    do_reset;
    run_start;
    repeat (7) tick;
    checks++;
    if (reg_write !== 1'b1) begin
      fails++; $display("FAIL stopwb_rw: got %b want 1", reg_write);
    end
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checks++;
    if ({halted, busy} !== 2'b10 || instr_addr !== 32'd8 || retired !== 32'd2) begin
      fails++;
      $display("FAIL stopwb_halt: h/b=%b addr=%h retired=%0d", {halted, busy}, instr_addr, retired);
    end
    run_start;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    repeat (2) tick;
    checks++;
    if (reg_write !== 1'b1) begin
      fails++; $display("FAIL stopf_rw: got %b want 1", reg_write);
    end
    tick;
    checks++;
    if (halted !== 1'b1 || instr_addr !== 32'd12 || retired !== 32'd3) begin
      fails++;
      $display("FAIL stopf_halt: h=%b addr=%h retired=%0d want 1/c/3", halted, instr_addr, retired);
    end
    run_start;
    repeat (4) tick;
    checks++;
    if ({busy, halted} !== 2'b10 || instr_addr !== 32'd16) begin
      fails++; $display("FAIL stop_cleared: b/h=%b addr=%h want 10/10", {busy, halted}, instr_addr);
    end
  endtask

  task automatic test_idle_stop;
    fill_mem(ADD);
    do_reset;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    checks++;
    if ({busy, halted} !== 2'b00 || instr_addr !== 32'd0) begin
      fails++; $display("FAIL idle_stop: b/h=%b addr=%h want 00/0", {busy, halted}, instr_addr);
    end
    start = 1'b1;
    stop = 1'b1;
    tick;
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL start_wins: busy=%b want 1", busy);
    end
    repeat (4) tick;
    checks++;
    if ({busy, halted} !== 2'b10 || instr_addr !== 32'd4) begin
      fails++; $display("FAIL start_nostop: b/h=%b addr=%h want 10/4", {busy, halted}, instr_addr);
    end
  endtask

  task automatic test_reset_mid;
    fill_mem(ADD);
    do_reset;
    run_start;
    repeat (2) tick;
    checks++;
    if (alu_op !== 2'b10) begin
      fails++; $display("FAIL mid_exec: alu_op=%b want 10", alu_op);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({busy, halted, reg_write} !== 3'b000 || instr_addr !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset: b/h/rw=%b addr=%h", {busy, halted, reg_write}, instr_addr);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || reg_write !== 1'b0 || retired !== 32'd0 || ir !== 32'd0) begin
      fails++; $display("FAIL mid_after: busy=%b rw=%b retired=%0d ir=%h", busy, reg_write, retired, ir);
    end
  endtask

  task automatic test_max_wrap;
    do_reset;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    repeat (3) tick;
    checks++;
    if (instr_addr2 !== 32'hFFFF_FFF8 || reg_write2 !== 1'b1) begin
      fails++; $display("FAIL wrap_i1: addr=%h rw=%b want fffffff8/1", instr_addr2, reg_write2);
    end
    repeat (4) tick;
    checks++;
    if (instr_addr2 !== 32'hFFFF_FFFC || alu_op2 !== 2'b10) begin
      fails++; $display("FAIL wrap_i2: addr=%h op=%b want fffffffc/10", instr_addr2, alu_op2);
    end
    tick;
    checks++;
    if (halted2 !== 1'b1 || busy2 !== 1'b0 || retired2 !== 32'd2 || instr_addr2 !== 32'd0) begin
      fails++;
      $display("FAIL wrap_halt: h=%b b=%b retired=%0d addr=%h", halted2, busy2, retired2, instr_addr2);
    end
    checks++;
    if (ir2 !== ADD || illegal2 !== 1'b0) begin
      fails++; $display("FAIL wrap_ir: ir=%h illegal=%b", ir2, illegal2);
    end
    repeat (3) tick;
    checks++;
    if (halted2 !== 1'b1 || retired2 !== 32'd2) begin
      fails++; $display("FAIL wrap_hold: h=%b retired=%0d want 1/2", halted2, retired2);
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step;
    fill_mem(ADD);
    do_reset;
    run_start;
    repeat (4) tick;
    checks++;
    if ({busy, halted} !== 2'b00 || retired !== 32'd1 || instr_addr !== 32'd4) begin
      fails++; $display("FAIL step_pause1: b/h=%b retired=%0d", {busy, halted}, retired);
    end
    repeat (3) tick;
    checks++;
    if (busy !== 1'b0 || retired !== 32'd1) begin
      fails++; $display("FAIL step_wait: busy=%b retired=%0d want 0/1", busy, retired);
    end
    step = 1'b1;
    tick;
    step = 1'b0;
    checks++;
    if (busy !== 1'b1 || instr_addr !== 32'd4) begin
      fails++; $display("FAIL step_go: busy=%b addr=%h want 1/4", busy, instr_addr);
    end
    repeat (4) tick;
    checks++;
    if (busy !== 1'b0 || retired !== 32'd2 || instr_addr !== 32'd8) begin
      fails++; $display("FAIL step_pause2: busy=%b retired=%0d addr=%h", busy, retired, instr_addr);
    end
    step = 1'b1;
    stop = 1'b1;
    tick;
    step = 1'b0;
    stop = 1'b0;
    checks++;
    if (halted !== 1'b1 || retired !== 32'd2) begin
      fails++; $display("FAIL step_stop: halted=%b retired=%0d want 1/2", halted, retired);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_add;
    test_rd_zero;
    test_reset_mid;
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step;
`else
    test_back_to_back;
    test_illegal;
    test_stop;
    test_idle_stop;
    test_max_wrap;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/r_format_sequencer.md
Name: r_format_sequencer

Overview:
- Multi-cycle controller that sequences the R-format datapath (PC, instruction memory, register file, ALU, ALU control).
- Owns the PC and instruction register (IR) and splits each instruction into FETCH / DECODE / EXECUTE / WRITEBACK.
- Drives ALUOp and RegWrite with exact timing, detects non-R-type opcodes, and supports start/stop run control with a retired-instruction counter.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 32'd4, PC increment per retired instruction.
- MAX_INSTR, 32'd0, auto-halt after this many retirements; 0 = unlimited.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin/resume execution; sampled in IDLE and HALT only.
- stop  in  1  request halt at the next instruction boundary; sampled every cycle.
- instr_addr  out  32  current PC, drives instruction memory address.
- instruction  in  32  combinational instruction-memory data for instr_addr.
- ir  out  32  latched instruction; feeds RF addresses, shamt, funct.
- alu_op  out  2  2'b10 in EXECUTE and WRITEBACK, else 2'b00.
- reg_write  out  1  RF write enable.
- busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: non-zero opcode seen.
- retired  out  32  count of completed instructions.

Behaviour:
- Reset (next edge with rst=1): state=IDLE, instr_addr=PC_RESET, ir=0, illegal=0, retired=0, stop_pending=0. alu_op=00, reg_write=0, busy=0, halted=0. rst overrides all other inputs, including mid-instruction; no partial write occurs.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. Encoding is free.
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: ir <= instruction -> DECODE.
- DECODE: if ir[31:26] != 6'b0, set illegal=1 -> HALT with PC unchanged and retired unchanged. Otherwise -> EXECUTE.
- EXECUTE: alu_op=10; one settling cycle -> WRITEBACK.
- WRITEBACK: alu_op=10. reg_write=1 for exactly this cycle iff ir[15:11] != 0; writes to $0 are suppressed. At the edge leaving WRITEBACK:
  - pc <= pc + PC_STEP, wrapping modulo 2^32.
  - retired <= retired + 1, saturating at 32'hFFFF_FFFF.
  - Next state is HALT if stop_pending, or if MAX_INSTR != 0 and the new retired == MAX_INSTR; otherwise FETCH.
- Latency: 4 cycles per legal instruction. First FETCH is the cycle after start is sampled.
- stop: sets stop_pending in any busy state, including a stop arriving in the WRITEBACK cycle itself (that instruction still completes, then HALT). stop in IDLE or HALT is ignored. stop_pending clears on entry to HALT. stop and start together in IDLE: start wins; stop is ignored.
- HALT: start=1 -> FETCH at current PC, and clears illegal. If halted by an illegal opcode, the same word is refetched and halts again unless memory has changed.
- reg_write and alu_op are decoded from state and ir only; no glitch paths from instruction.
- busy and halted are state decodes and are mutually exclusive.

Optional Feature:
- Macro SEQ_SINGLE_STEP_EN.
- Defined: adds input port step (1 bit) and state PAUSE. WRITEBACK goes to PAUSE instead of FETCH whenever it would otherwise go to FETCH. PAUSE: busy=0, halted=0. step=1 -> FETCH; stop=1 -> HALT; step and stop together -> HALT.
- Not defined: no step port, no PAUSE state; free-running as above.

Test Plan:
- Reset, then start pulse with memory word 0 = add $3,$1,$2 (32'h0022_1820) and $1=5, $2=7 -> reg_write high only in cycle 4 after start sampling; $3=12; instr_addr 0->4; retired=1.
- Three back-to-back R-type instructions, no stop -> exactly one reg_write pulse every 4 cycles; instr_addr 0,4,8,12; alu_op=10 only in EXECUTE/WRITEBACK.
- Instruction with rd=0 (32'h0022_0020) -> reg_write stays 0 throughout; retired still increments; $0 reads 0.
- Word 32'h8C01_0000 (lw opcode) at PC 8 -> illegal=1, halted=1 after DECODE; instr_addr remains 8; retired unchanged. Then start -> illegal clears and halts again at 8.
- stop asserted in the WRITEBACK cycle of instruction 2, and separately in the FETCH cycle -> in each case that instruction completes, then HALT next; PC points to the following instruction. Reset asserted in EXECUTE -> IDLE, no reg_write, instr_addr=PC_RESET.
- MAX_INSTR=2, and separately pc preset near 32'hFFFF_FFFC -> auto-halt after second retirement with retired=2; PC wraps to 0. With SEQ_SINGLE_STEP_EN, each step pulse yields exactly one retirement.
